// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: 3-deep destination scoreboard, RAW stall, redirect flush, halt drain.
// Define HAZARD_CTRL_FORWARD_EN when EX/MEM forwarding exists downstream (load-use stalls only).
module hazard_ctrl #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_use1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_halt,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             pc_hold,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } sb_t;

  state_t state_q, state_d;
  sb_t    sb_ex, sb_mem, sb_wb, sb_ex_d;
  logic   hit_ex, hit_mem, haz;

  function automatic logic sb_hit(input sb_t e, input logic u1, input logic [REG_W-1:0] s1,
                                  input logic u2, input logic [REG_W-1:0] s2);
    return (u1 && e.v && (e.rd == s1)) || (u2 && e.v && (e.rd == s2));
  endfunction

  assign hit_ex  = sb_hit(sb_ex,  id_use1, id_rs1, id_use2, id_rs2);
  assign hit_mem = sb_hit(sb_mem, id_use1, id_rs1, id_use2, id_rs2);

  // WB is never checked: the register file bypasses same-cycle writes to reads.
`ifdef HAZARD_CTRL_FORWARD_EN
  assign haz = id_valid && hit_ex && sb_ex.ld;
  logic unused_sb;
  assign unused_sb = ^{hit_mem, sb_mem.rd, sb_mem.ld, sb_wb.rd, sb_wb.ld};
`else
  assign haz = id_valid && (hit_ex || hit_mem);
  logic unused_sb;
  assign unused_sb = ^{sb_mem.ld, sb_wb.rd, sb_wb.ld};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      sb_ex   <= '0;
      sb_mem  <= '0;
      sb_wb   <= '0;
    end else begin
      state_q <= state_d;
      sb_ex   <= sb_ex_d;
      sb_mem  <= sb_ex;
      sb_wb   <= sb_mem;
    end
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    pc_hold    = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = 1'b0;
    sb_ex_d    = '0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          // Anything in ID is wrong-path, so a pending hazard is simply dropped.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else begin
          stall      = haz;
          pc_hold    = haz;
          flush_idex = haz;
          if (id_valid && id_halt && !haz) begin
            state_d = DRAIN;
          end else if (id_valid && id_regwrite && !haz) begin
            sb_ex_d = '{v: 1'b1, rd: id_rd, ld: id_memread};
          end
        end
      end
      DRAIN: begin
        pc_hold    = 1'b1;
        flush_ifid = 1'b1;
        if (!(sb_ex.v || sb_mem.v || sb_wb.v)) state_d = HALT;
      end
      HALT: begin
        pc_hold    = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with CNT_W=4 checks counter saturation.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARD_EN
  localparam int EXP_LU  = 1;
  localparam int EXP_ALU = 0;
`else
  localparam int EXP_LU  = 2;
  localparam int EXP_ALU = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use1, id_use2, id_regwrite, id_memread, id_halt, ex_redirect;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic stall, pc_hold, flush_ifid, flush_idex, halted;
  logic [15:0] stall_cnt;
  logic stall4, pc_hold4, flush_ifid4, flush_idex4, halted4;
  logic [3:0] stall_cnt4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_use1(id_use1),
    .id_rs2(id_rs2), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall), .pc_hold(pc_hold), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_use1(id_use1),
    .id_rs2(id_rs2), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall4), .pc_hold(pc_hold4), .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
    .halted(halted4), .stall_cnt(stall_cnt4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                       input logic rw, input logic mr, input logic h, input logic redir);
    id_valid = v; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_halt = h; ex_redirect = redir;
    #1;
  endtask

  task automatic bubble();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bubble();
    step();
    step();
    rst = 1'b0;
    bubble();
    exp_cnt = 0;
    checks++;
    if ({stall, pc_hold, flush_ifid, flush_idex, halted} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {stall, pc_hold, flush_ifid, flush_idex, halted});
    end
    checks++;
    if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, stall_cnt4);
    end
  endtask

  // LD r3 followed by a consumer of r3 in rs1; stalls for exactly EXP_LU cycles.
  task automatic load_use(input string tag);
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= EXP_LU; i++) begin
      checks++;
      if (stall !== (i < EXP_LU) || pc_hold !== (i < EXP_LU) || flush_idex !== (i < EXP_LU)
          || flush_ifid !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d: stall/pc_hold/flush_idex/flush_ifid got %b%b%b%b expected %b%b%b0",
                 tag, i, stall, pc_hold, flush_idex, flush_ifid, i < EXP_LU, i < EXP_LU, i < EXP_LU);
      end
      step();
    end
    exp_cnt += EXP_LU;
    bubble();
  endtask

  task automatic test_load_use();
    load_use("load_use");
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_alu_dep();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= EXP_ALU; i++) begin
      checks++;
      if (stall !== (i < EXP_ALU) || pc_hold !== (i < EXP_ALU)) begin
        errors++;
        $display("FAIL alu_dep cyc%0d: stall/pc_hold got %b%b expected %b%b",
                 i, stall, pc_hold, i < EXP_ALU, i < EXP_ALU);
      end
      step();
    end
    exp_cnt += EXP_ALU;
    bubble();
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL alu_dep_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    step(); step(); step();
  endtask

  task automatic test_redirect();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    // Would-be load-use consumer (itself a load of r5) killed by a same-cycle redirect.
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({stall, pc_hold, flush_ifid, flush_idex} !== 4'b0011) begin
      errors++;
      $display("FAIL redirect: stall/pc_hold/flush_ifid/flush_idex got %b expected 0011",
               {stall, pc_hold, flush_ifid, flush_idex});
    end
    step();
    drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL redirect_sb_cleared: stall got %b expected 0", stall);
    end
    step();
    bubble();
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL redirect_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    step(); step(); step();
  endtask

  task automatic test_halt_drain();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pc_hold !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL halt_in_id: pc_hold/stall got %b%b expected 00", pc_hold, stall);
    end
    step();
    for (int i = 1; i <= 6; i++) begin
      // Redirect on the first drain cycle must be ignored.
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, i == 1);
      checks++;
      if (halted !== (i >= 4) || pc_hold !== 1'b1 || flush_ifid !== 1'b1
          || flush_idex !== (i >= 4) || stall !== 1'b0) begin
        errors++;
        $display("FAIL drain cyc%0d: halted/pc_hold/flush_ifid/flush_idex/stall got %b%b%b%b%b expected %b11%b0",
                 i, halted, pc_hold, flush_ifid, flush_idex, stall, i >= 4, i >= 4);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_drain();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    load_use("pre_drain_lu");
    checks++;
    if (stall_cnt !== 16'(EXP_LU)) begin
      errors++;
      $display("FAIL pre_drain_cnt: got %0d expected %0d", stall_cnt, EXP_LU);
    end
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    bubble();
    checks++;
    if (pc_hold !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL in_drain: pc_hold/halted got %b%b expected 10", pc_hold, halted);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || pc_hold !== 1'b0 || flush_ifid !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_rst: halted/pc_hold/flush_ifid got %b%b%b cnt %0d expected 000 cnt 0",
               halted, pc_hold, flush_ifid, stall_cnt);
    end
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall !== 1'b0 || pc_hold !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_consumer: stall/pc_hold got %b%b expected 00", stall, pc_hold);
    end
    step();
    bubble();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_rst_cnt: got %0d expected 0", stall_cnt);
    end
    step(); step(); step();
  endtask

  task automatic test_cnt_saturate();
    for (int k = 0; k < 20; k++) load_use("sat_lu");
    checks++;
    if (stall_cnt4 !== 4'd15) begin
      errors++;
      $display("FAIL cnt4_saturate: got %0d expected 15", stall_cnt4);
    end
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL cnt16_total: got %0d expected %0d", stall_cnt, exp_cnt);
    end
    load_use("sat_hold_lu");
    checks++;
    if (stall_cnt4 !== 4'd15) begin
      errors++;
      $display("FAIL cnt4_hold: got %0d expected 15", stall_cnt4);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_dep();
    test_redirect();
    test_halt_drain();
    test_reset_mid_drain();
    test_cnt_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
